// File: rtl/midi_cc_param_bank_pkg.sv
// Shared types and constants for the MIDI CC parameter bank: message format, default CC bindings
// and power-on parameter values (MSB form, left-justified when the bank runs 14-bit).
package midi_cc_param_bank_pkg;

    typedef enum logic [3:0] {
        MsgNoteOff         = 4'h8,
        MsgNoteOn          = 4'h9,
        MsgPolyPressure    = 4'hA,
        MsgControlChange   = 4'hB,
        MsgProgramChange   = 4'hC,
        MsgChannelPressure = 4'hD,
        MsgPitchBend       = 4'hE,
        MsgSystem          = 4'hF
    } msg_type_e;

    typedef struct packed {
        msg_type_e  msg_type;
        logic [3:0] channel;
        logic [6:0] data_byte1;
        logic [6:0] data_byte2;
    } message_t;

    typedef logic [4:0] param_idx_t;

    typedef enum logic [0:0] {
        StIdle,
        StArmed
    } learn_state_e;

    localparam logic [6:0] CC_RESET_ALL  = 7'd121;
    localparam logic [6:0] CC_LSB_OFFSET = 7'd32;

    // Sized for the largest bank; smaller banks use the leading entries.
    localparam logic [6:0] DEFAULT_CC_MAP [32] = '{
        7'd1,  7'd2,  7'd5,  7'd7,  7'd10, 7'd11, 7'd12, 7'd13,
        7'd16, 7'd17, 7'd18, 7'd19, 7'd70, 7'd71, 7'd72, 7'd73,
        7'd75, 7'd76, 7'd77, 7'd78, 7'd79, 7'd80, 7'd81, 7'd82,
        7'd83, 7'd84, 7'd85, 7'd86, 7'd87, 7'd88, 7'd89, 7'd90
    };

    localparam logic [6:0] DEFAULT_VALUES [32] = '{
        7'd0,  7'd10, 7'd20, 7'd50, 7'd64, 7'd64, 7'd0,  7'd127,
        7'd64, 7'd32, 7'd0,  7'd0,  7'd64, 7'd96, 7'd64, 7'd5,
        7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,
        7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0,  7'd0
    };

endpackage

// File: rtl/param_change_arbiter.sv
// Pending-change bitmap with lowest-index-first valid/ready notification.
// New changes win over a same-cycle pop of the same index; repeated changes coalesce.
module param_change_arbiter #(
    parameter int unsigned NUM_PARAMS = 16,
    parameter int unsigned IDX_W      = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                  clock_50_000_000,
    input  logic                  reset_l,
    input  logic [NUM_PARAMS-1:0] set_mask,
    input  logic                  set_all,
    input  logic                  change_ready,
    output logic                  change_valid,
    output logic [IDX_W-1:0]      change_index
);

    logic [NUM_PARAMS-1:0] pending_q, pending_d;
    logic [NUM_PARAMS-1:0] pop_mask;

    always_comb begin
        change_index = '0;
        for (int i = int'(NUM_PARAMS) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                change_index = IDX_W'(i);
            end
        end
        change_valid = |pending_q;

        pop_mask = '0;
        if (change_valid && change_ready) begin
            pop_mask[change_index] = 1'b1;
        end

        if (set_all) begin
            pending_d = '1;
        end else begin
            pending_d = (pending_q & ~pop_mask) | set_mask;
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/midi_cc_param_bank.sv
// MIDI Control-Change to parameter-register mapper with channel filter and optional 14-bit values.
// Define MIDI_CC_LEARN_EN to add runtime CC rebinding (learn_req/learn_index/learn_busy).
module midi_cc_param_bank
    import midi_cc_param_bank_pkg::*;
#(
    parameter int unsigned NUM_PARAMS = 16,
    parameter int unsigned VALUE_W    = 7,
    parameter int unsigned IDX_W      = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                                clock_50_000_000,
    input  logic                                reset_l,
    input  message_t                            message,
    input  logic                                message_ready,
    input  logic [15:0]                         channel_mask,
    output logic [NUM_PARAMS-1:0][VALUE_W-1:0]  param_values,
    output logic                                change_valid,
    output logic [IDX_W-1:0]                    change_index,
    input  logic                                change_ready
`ifdef MIDI_CC_LEARN_EN
    ,
    input  logic                                learn_req,
    input  logic [IDX_W-1:0]                    learn_index,
    output logic                                learn_busy
`endif
);

    localparam int unsigned SHIFT = VALUE_W - 7;
    localparam bit          WIDE  = (VALUE_W == 14);

    logic [NUM_PARAMS-1:0][6:0]         cc_map;
    logic [NUM_PARAMS-1:0][6:0]         default_map;
    logic [NUM_PARAMS-1:0][VALUE_W-1:0] default_values;
    logic [NUM_PARAMS-1:0][VALUE_W-1:0] values_q, values_d;

    logic               lsb_valid_q, lsb_valid_d;
    logic [IDX_W-1:0]   lsb_idx_q, lsb_idx_d;

    logic               accept, is_reset_all, is_lsb, is_msb, hit;
    logic [6:0]         cc_num, cc_key, data;
    logic [IDX_W-1:0]   hit_idx;
    logic [VALUE_W-1:0] msb_value;

    logic                  learn_take;
    logic [IDX_W-1:0]      learn_target;
    logic [NUM_PARAMS-1:0] set_mask;
    logic                  set_all;

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_defaults
        assign default_values[g] = VALUE_W'(DEFAULT_VALUES[g]) << SHIFT;
        assign default_map[g]    = DEFAULT_CC_MAP[g];
    end

    always_comb begin
        cc_num       = message.data_byte1;
        data         = message.data_byte2;
        accept       = message_ready && (message.msg_type == MsgControlChange) &&
                       channel_mask[message.channel];
        is_reset_all = accept && (cc_num == CC_RESET_ALL);
        // In 14-bit mode CC 32..63 carry the LSB of the parameter bound to CC-32.
        is_lsb       = WIDE && (cc_num[6:5] == 2'b01);
        is_msb       = WIDE && (cc_num[6:5] == 2'b00);
        cc_key       = is_lsb ? (cc_num - CC_LSB_OFFSET) : cc_num;
        msb_value    = VALUE_W'(data) << SHIFT;

        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(NUM_PARAMS) - 1; i >= 0; i--) begin
            if (cc_map[i] == cc_key) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

`ifdef MIDI_CC_LEARN_EN
    learn_state_e               learn_state_q, learn_state_d;
    logic [IDX_W-1:0]           learn_idx_q, learn_idx_d;
    logic [NUM_PARAMS-1:0][6:0] cc_map_q, cc_map_d;

    always_comb begin
        learn_state_d = learn_state_q;
        learn_idx_d   = learn_idx_q;
        cc_map_d      = cc_map_q;
        learn_take    = 1'b0;
        unique case (learn_state_q)
            StIdle: begin
                if (learn_req) begin
                    learn_state_d = StArmed;
                    learn_idx_d   = learn_index;
                end
            end
            StArmed: begin
                if (accept && !is_reset_all && !is_lsb) begin
                    learn_take            = 1'b1;
                    cc_map_d[learn_idx_q] = cc_num;
                    learn_state_d         = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            learn_state_q <= StIdle;
            learn_idx_q   <= '0;
            cc_map_q      <= default_map;
        end else begin
            learn_state_q <= learn_state_d;
            learn_idx_q   <= learn_idx_d;
            cc_map_q      <= cc_map_d;
        end
    end

    assign learn_busy   = (learn_state_q == StArmed);
    assign learn_target = learn_idx_q;
    assign cc_map       = cc_map_q;
`else
    assign learn_take   = 1'b0;
    assign learn_target = '0;
    assign cc_map       = default_map;
`endif

    always_comb begin
        values_d    = values_q;
        set_mask    = '0;
        set_all     = 1'b0;
        lsb_valid_d = lsb_valid_q;
        lsb_idx_d   = lsb_idx_q;

        if (is_reset_all) begin
            values_d    = default_values;
            set_all     = 1'b1;
            lsb_valid_d = 1'b0;
        end else if (learn_take) begin
            values_d[learn_target] = msb_value;
            set_mask[learn_target] = 1'b1;
            if (is_msb) begin
                lsb_valid_d = 1'b1;
                lsb_idx_d   = learn_target;
            end
        end else if (accept && hit) begin
            if (is_lsb) begin
                // LSB only pairs with the most recent MSB, and only for that same parameter.
                if (lsb_valid_q && (lsb_idx_q == hit_idx)) begin
                    values_d[hit_idx][6:0] = data;
                    set_mask[hit_idx]      = 1'b1;
                end
            end else begin
                values_d[hit_idx] = msb_value;
                set_mask[hit_idx] = 1'b1;
                if (is_msb) begin
                    lsb_valid_d = 1'b1;
                    lsb_idx_d   = hit_idx;
                end
            end
        end
    end

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            values_q    <= default_values;
            lsb_valid_q <= 1'b0;
            lsb_idx_q   <= '0;
        end else begin
            values_q    <= values_d;
            lsb_valid_q <= lsb_valid_d;
            lsb_idx_q   <= lsb_idx_d;
        end
    end

    assign param_values = values_q;

    param_change_arbiter #(
        .NUM_PARAMS (NUM_PARAMS),
        .IDX_W      (IDX_W)
    ) u_arbiter (
        .clock_50_000_000 (clock_50_000_000),
        .reset_l          (reset_l),
        .set_mask         (set_mask),
        .set_all          (set_all),
        .change_ready     (change_ready),
        .change_valid     (change_valid),
        .change_index     (change_index)
    );

endmodule
